display_scan: RTL

Time-multiplexed scan controller for the multi-digit 7-segment display. Holds a frame-buffered copy of a DIGITS-digit hex/BCD value and sequences one digit at a time through the shared single-digit 7-segment decoder. Drives that decoder's `num`/`decimal` inputs and a one-hot digit enable. Adds leading-zero blanking, 8-level brightness (PWM within each digit slot) and tear-free frame-boundary updates via a load/pending handshake.

---
 rtl/display_scan.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
// Module      : display_scan
// Description : Time-multiplexed scan controller for a multi-digit 7-segment
//               display. Holds a frame-buffered copy of a DIGITS-digit value
//               and presents one digit at a time to a shared single-digit
//               decoder, with leading-zero blanking, 8-level PWM brightness
//               inside each digit slot and tear-free frame-boundary updates.
//
// Ports       : clk            system clock
//               reset_n        asynchronous active-low reset
//               load           strobe, captures value/dp into pending register
//               value[4*D-1:0] digit codes, [3:0] is digit 0 (rightmost)
//               dp[D-1:0]      decimal-point request per digit
//               bright[2:0]    brightness 0 (1/8 duty) .. 7 (full duty)
//               num[3:0]       code for the active digit (4'hF when blanked)
//               decimal        decimal point for the active digit
//               digit_en[D-1:0] one-hot digit select, zero when off/blanked
//               frame_done     pulse on the last cycle of the last digit slot
//               update_pending high while a loaded value awaits the boundary
//
// Revision    : 1.0  initial release
// ============================================================================
module display_scan #(
    parameter int DIGITS     = 4,
    parameter int DWELL      = 50000,
    parameter int BLANK_LEAD = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [2:0]            bright,
    output logic [3:0]            num,
    output logic                  decimal,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done,
    output logic                  update_pending
);

    localparam int c_CNT_W  = $clog2(DWELL);
    localparam int c_IDX_W  = $clog2(DIGITS);
    // (bright+1) <= 8 and DWELL <= 2**c_CNT_W, so the product fits c_CNT_W+4.
    localparam int c_PROD_W = c_CNT_W + 4;

    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [4*DIGITS-1:0]  r_shadow_val;
    logic [DIGITS-1:0]    r_shadow_dp;
    logic [4*DIGITS-1:0]  r_pend_val;
    logic [DIGITS-1:0]    r_pend_dp;
    logic                 r_pend_flag;
    logic [c_CNT_W:0]     r_on_cycles;

    logic                 w_slot_end;
    logic                 w_frame_end;
    logic [c_PROD_W-1:0]  w_prod;
    logic [c_CNT_W:0]     w_on_new;
    logic [c_CNT_W:0]     w_on_now;
    logic                 w_lit;
    logic [DIGITS-1:0]    w_blank;
    logic                 w_blank_cur;
    logic [3:0]           w_nib;
    logic [DIGITS-1:0]    w_onehot;

    assign w_slot_end  = (r_cnt == c_CNT_W'(DWELL - 1));
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_W'(DIGITS - 1));

    // Full-width product before the shift so that no duty step is lost.
    assign w_prod   = (c_PROD_W'(bright) + c_PROD_W'(1)) * c_PROD_W'(DWELL);
    assign w_on_new = (c_CNT_W + 1)'(w_prod >> 3);

    // On the first cycle of a slot the latched on-time is being loaded in the
    // same edge, so use the freshly computed value for that cycle.
    assign w_on_now = (r_cnt == '0) ? w_on_new : r_on_cycles;
    assign w_lit    = ({1'b0, r_cnt} < w_on_now);

    assign w_nib    = r_shadow_val[{r_idx, 2'b00} +: 4];
    assign w_onehot = DIGITS'(1) << r_idx;

    // A digit is blanked when it and every more-significant digit is a zero
    // code without a decimal point; digit 0 always shows.
    generate
        if (BLANK_LEAD != 0) begin : g_blank
            always_comb begin
                logic w_run;
                w_run   = 1'b1;
                w_blank = '0;
                for (int i = DIGITS - 1; i >= 1; i--) begin
                    w_run      = w_run & (r_shadow_val[4*i +: 4] == 4'h0) & ~r_shadow_dp[i];
                    w_blank[i] = w_run;
                end
            end
        end else begin : g_no_blank
            assign w_blank = '0;
        end
    endgenerate

    assign w_blank_cur = w_blank[r_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt          <= '0;
            r_idx          <= '0;
            r_shadow_val   <= '0;
            r_shadow_dp    <= '0;
            r_pend_val     <= '0;
            r_pend_dp      <= '0;
            r_pend_flag    <= 1'b0;
            r_on_cycles    <= '0;
            num            <= 4'h0;
            decimal        <= 1'b0;
            digit_en       <= '0;
            frame_done     <= 1'b0;
            update_pending <= 1'b0;
        end else begin
            // Slot and digit sequencing
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= w_frame_end ? '0 : r_idx + c_IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (r_cnt == '0) begin
                r_on_cycles <= w_on_new;
            end

            // Load / frame-boundary handshake; a load landing exactly on the
            // boundary bypasses the pending register.
            if (load) begin
                if (w_frame_end) begin
                    r_shadow_val <= value;
                    r_shadow_dp  <= dp;
                    r_pend_flag  <= 1'b0;
                end else begin
                    r_pend_val   <= value;
                    r_pend_dp    <= dp;
                    r_pend_flag  <= 1'b1;
                end
            end else if (w_frame_end && r_pend_flag) begin
                r_shadow_val <= r_pend_val;
                r_shadow_dp  <= r_pend_dp;
                r_pend_flag  <= 1'b0;
            end

            // Registered outputs, one cycle behind the state they reflect
            num            <= w_blank_cur ? 4'hF : w_nib;
            decimal        <= ~w_blank_cur & r_shadow_dp[r_idx];
            digit_en       <= (!w_blank_cur && w_lit) ? w_onehot : '0;
            frame_done     <= w_frame_end;
            update_pending <= r_pend_flag;
        end
    end

endmodule
`default_nettype wire
